// File: rtl/axi_lite_reg_selftest_master.sv
// AXI4-Lite master that writes a pattern to NUM_REGS registers, reads each back and
// reports pass/fail with an error count, the first failing index and a per-wait timeout.
module axi_lite_reg_selftest_master #(
  parameter int                              C_M_AXI_ADDR_WIDTH = 32,
  parameter int                              C_M_AXI_DATA_WIDTH = 32,
  parameter int                              NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = '0,
  parameter int unsigned                     ADDR_STRIDE        = 4,
  parameter logic [31:0]                     PATTERN_SEED       = 32'h0101FFFF,
  parameter logic [31:0]                     PATTERN_STEP       = 32'h11111111,
  parameter int                              TIMEOUT_CYCLES     = 1024
) (
  input  logic                                                 ACLK,
  input  logic                                                 ARESET,
  input  logic                                                 start,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 pass,
  output logic                                                 timeout,
  output logic [$clog2(NUM_REGS+1)-1:0]                        err_count,
  output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0]   first_err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                        M_AXI_AWADDR,
  output logic [2:0]                                           M_AXI_AWPROT,
  output logic                                                 M_AXI_AWVALID,
  input  logic                                                 M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]                        M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]                      M_AXI_WSTRB,
  output logic                                                 M_AXI_WVALID,
  input  logic                                                 M_AXI_WREADY,
  input  logic [1:0]                                           M_AXI_BRESP,
  input  logic                                                 M_AXI_BVALID,
  output logic                                                 M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                        M_AXI_ARADDR,
  output logic [2:0]                                           M_AXI_ARPROT,
  output logic                                                 M_AXI_ARVALID,
  input  logic                                                 M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]                        M_AXI_RDATA,
  input  logic [1:0]                                           M_AXI_RRESP,
  input  logic                                                 M_AXI_RVALID,
  output logic                                                 M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int EW = $clog2(NUM_REGS + 1);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [AW-1:0] STRIDE_A = AW'(ADDR_STRIDE);
  localparam logic [DW-1:0] SEED_D   = DW'(PATTERN_SEED);
  localparam logic [DW-1:0] STEP_D   = DW'(PATTERN_STEP);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_B    = 3'd2,
    S_AR   = 3'd3,
    S_R    = 3'd4,
    S_CHK  = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      rresp_q;
  logic [TW-1:0]   tmo_cnt_q;
  logic [EW-1:0]   err_cnt_q;
  logic [IW-1:0]   first_err_q;
  logic            have_err_q;
  logic            wr_err_q;
  logic            issued_q;
  logic            aw_done_q;
  logic            w_done_q;
  logic            awvalid_q;
  logic            wvalid_q;
  logic            bready_q;
  logic            arvalid_q;
  logic            rready_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            timeout_q;

  logic            aw_done_d;
  logic            w_done_d;
  logic            wait_d;
  logic            progress_d;
  logic            abort_d;
  logic            chk_fail_d;

  // Handshake progress, timeout abort and readback verdict for the current state.
  always_comb begin
    aw_done_d  = aw_done_q | (awvalid_q & M_AXI_AWREADY);
    w_done_d   = w_done_q  | (wvalid_q  & M_AXI_WREADY);
    wait_d     = 1'b0;
    progress_d = 1'b0;
    case (state_q)
      S_WR: begin
        wait_d     = 1'b1;
        progress_d = issued_q & aw_done_d & w_done_d;
      end
      S_B: begin
        wait_d     = 1'b1;
        progress_d = bready_q & M_AXI_BVALID;
      end
      S_AR: begin
        wait_d     = 1'b1;
        progress_d = arvalid_q & M_AXI_ARREADY;
      end
      S_R: begin
        wait_d     = 1'b1;
        progress_d = rready_q & M_AXI_RVALID;
      end
      default: begin
        wait_d     = 1'b0;
        progress_d = 1'b0;
      end
    endcase
    abort_d    = wait_d & ~progress_d & (tmo_cnt_q == TMO_LAST);
    chk_fail_d = wr_err_q | (rresp_q != 2'b00) | (rdata_q != data_q);
  end

  // Test sequencer: one register per WR/B/AR/R/CHK pass, all outputs registered.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      tmo_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      have_err_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      issued_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (abort_d) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      timeout_q <= 1'b1;
      state_q   <= S_FIN;
    end else begin
      if (wait_d && !progress_d) begin
        tmo_cnt_q <= tmo_cnt_q + TW'(1);
      end else begin
        tmo_cnt_q <= '0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            have_err_q  <= 1'b0;
            idx_q       <= '0;
            addr_q      <= BASE_ADDR;
            data_q      <= SEED_D;
            issued_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            state_q     <= S_WR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WR: begin
          // First WR cycle only raises both VALIDs; handshakes are tracked per channel.
          if (!issued_q) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            issued_q  <= 1'b1;
          end else if (progress_d) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= S_B;
          end else begin
            awvalid_q <= awvalid_q & ~M_AXI_AWREADY;
            wvalid_q  <= wvalid_q  & ~M_AXI_WREADY;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        S_B: begin
          if (progress_d) begin
            bready_q  <= 1'b0;
            wr_err_q  <= (M_AXI_BRESP != 2'b00);
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
          end else begin
            state_q <= S_B;
          end
        end
        S_AR: begin
          if (progress_d) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end else begin
            state_q <= S_AR;
          end
        end
        S_R: begin
          if (progress_d) begin
            rready_q <= 1'b0;
            rdata_q  <= M_AXI_RDATA;
            rresp_q  <= M_AXI_RRESP;
            state_q  <= S_CHK;
          end else begin
            state_q <= S_R;
          end
        end
        S_CHK: begin
          if (chk_fail_d) begin
            err_cnt_q <= err_cnt_q + EW'(1);
            if (!have_err_q) begin
              first_err_q <= idx_q;
              have_err_q  <= 1'b1;
            end else begin
              first_err_q <= first_err_q;
            end
          end else begin
            err_cnt_q <= err_cnt_q;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= S_FIN;
          end else begin
            idx_q    <= idx_q + IW'(1);
            addr_q   <= addr_q + STRIDE_A;
            data_q   <= data_q + STEP_D;
            issued_q <= 1'b0;
            state_q  <= S_WR;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_cnt_q == '0) && !timeout_q;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_count     = err_cnt_q;
  assign first_err_idx = first_err_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = {(DW/8){1'b1}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_reg_selftest_master.sv
// Bench for the register self-test master: a configurable AXI4-Lite slave model drives
// the bus, and expected writes, reads and run verdicts are queued and popped on arrival.
`timescale 1ns/1ps
module tb_axi_lite_reg_selftest_master;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [2:0]  err_count;
  logic [1:0]  first_err_idx;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0] M_AXI_RDATA = 32'h0;

  always #5 ACLK = ~ACLK;

  axi_lite_reg_selftest_master #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr [4] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
  logic [31:0] exp_data [4] = '{32'h0101FFFF, 32'h12131110, 32'h23242221, 32'h34353332};

  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  logic [31:0] ra_q [$];
  logic [6:0]  res_q [$];

  // slave knobs
  int aw_delay = 0;
  bit ar_stuck = 1'b0;
  int flip_idx = -1;
  int berr_idx = -1;
  int hold_idx = -1;

  // slave state
  logic [31:0] mem [4];
  bit          aw_have, w_have, ar_have, b_acc, r_acc, wr_logged, b_held;
  logic [31:0] aw_addr, aw_first, w_data, ar_addr;
  int          aw_wait, aw_hi, w_hi, aw_len, w_len, ar_hi_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic log_write(input logic [31:0] a, input logic [31:0] d);
    chk("wr_expected", (wa_q.size() > 0), 1'b1);
    if (wa_q.size() > 0) begin
      chk("wr_addr", a, wa_q.pop_front());
      chk("wr_data", d, wd_q.pop_front());
    end
  endtask

  task automatic log_read(input logic [31:0] a);
    chk("rd_expected", (ra_q.size() > 0), 1'b1);
    if (ra_q.size() > 0) chk("rd_addr", a, ra_q.pop_front());
  endtask

  // Slave model: decides its inputs on the falling edge from the DUT's registered outputs.
  initial begin : slave
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00;
        aw_have = 1'b0; w_have = 1'b0; ar_have = 1'b0; b_acc = 1'b0; r_acc = 1'b0;
        wr_logged = 1'b0; b_held = 1'b0; aw_wait = 0; aw_hi = 0; w_hi = 0;
      end else begin
        if (M_AXI_BVALID) begin
          if (b_acc) M_AXI_BVALID = 1'b0;
        end else if (aw_have && w_have) begin
          if (!wr_logged) begin
            log_write(aw_addr, w_data);
            mem[aw_addr[3:2]] = w_data;
            wr_logged = 1'b1;
            aw_len = aw_hi; w_len = w_hi; aw_hi = 0; w_hi = 0;
          end
          b_held = (int'(aw_addr[3:2]) == hold_idx);
          if (!b_held) begin
            M_AXI_BVALID = 1'b1;
            M_AXI_BRESP  = (int'(aw_addr[3:2]) == berr_idx) ? 2'b10 : 2'b00;
            aw_have = 1'b0; w_have = 1'b0; wr_logged = 1'b0;
          end
        end
        b_acc = M_AXI_BVALID && M_AXI_BREADY;

        if (M_AXI_RVALID) begin
          if (r_acc) M_AXI_RVALID = 1'b0;
        end else if (ar_have) begin
          M_AXI_RDATA  = mem[ar_addr[3:2]] ^ ((int'(ar_addr[3:2]) == flip_idx) ? 32'h1 : 32'h0);
          M_AXI_RRESP  = 2'b00;
          M_AXI_RVALID = 1'b1;
          ar_have = 1'b0;
        end
        r_acc = M_AXI_RVALID && M_AXI_RREADY;

        M_AXI_AWREADY = 1'b0;
        if (M_AXI_AWVALID) begin
          aw_hi++;
          if (aw_hi == 1) begin
            aw_first = M_AXI_AWADDR;
            chk("aw_w_rise_together", M_AXI_WVALID, 1'b1);
          end
          if (!aw_have) begin
            if (aw_wait >= aw_delay) begin
              M_AXI_AWREADY = 1'b1; aw_have = 1'b1; aw_addr = M_AXI_AWADDR; aw_wait = 0;
              chk("awaddr_stable", M_AXI_AWADDR, aw_first);
              chk("awprot", M_AXI_AWPROT, 3'b000);
            end else begin
              aw_wait++;
            end
          end
        end

        M_AXI_WREADY = 1'b0;
        if (M_AXI_WVALID) begin
          w_hi++;
          if (!w_have) begin
            M_AXI_WREADY = 1'b1; w_have = 1'b1; w_data = M_AXI_WDATA;
            chk("wstrb", M_AXI_WSTRB, 4'hF);
          end
        end

        M_AXI_ARREADY = 1'b0;
        if (M_AXI_ARVALID) begin
          ar_hi_cnt++;
          if (!ar_have && !ar_stuck) begin
            M_AXI_ARREADY = 1'b1; ar_have = 1'b1; ar_addr = M_AXI_ARADDR;
            log_read(M_AXI_ARADDR);
            chk("arprot", M_AXI_ARPROT, 3'b000);
          end
        end
      end
    end
  end

  task automatic push_exp(input int nwr, input int nrd);
    for (int i = 0; i < nwr; i++) begin
      wa_q.push_back(exp_addr[i]);
      wd_q.push_back(exp_data[i]);
    end
    for (int i = 0; i < nrd; i++) ra_q.push_back(exp_addr[i]);
  endtask

  task automatic run_test(input string tag, input int nwr, input int nrd, input int e_err,
                          input int e_first, input bit e_pass, input bit e_to);
    logic [6:0] r;
    push_exp(nwr, nrd);
    res_q.push_back({e_to, e_pass, 2'(e_first), 3'(e_err)});
    ar_hi_cnt = 0;
    @(negedge ACLK); start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    chk({tag, ":busy"}, busy, 1'b1);
    chk({tag, ":done_cleared"}, done, 1'b0);
    for (int c = 0; c < 400 && done !== 1'b1; c++) @(negedge ACLK);
    chk({tag, ":done"}, done, 1'b1);
    chk({tag, ":busy_low"}, busy, 1'b0);
    chk({tag, ":res_expected"}, (res_q.size() > 0), 1'b1);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      chk({tag, ":err_count"}, err_count, r[2:0]);
      chk({tag, ":first_err_idx"}, first_err_idx, r[4:3]);
      chk({tag, ":pass"}, pass, r[5]);
      chk({tag, ":timeout"}, timeout, r[6]);
    end
    chk({tag, ":writes_left"}, wa_q.size(), 0);
    chk({tag, ":reads_left"}, ra_q.size(), 0);
  endtask

  initial begin : main
    repeat (3) @(negedge ACLK);
    chk("rst:busy", busy, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:pass", pass, 1'b0);
    chk("rst:timeout", timeout, 1'b0);
    chk("rst:err_count", err_count, 3'd0);
    chk("rst:first_err_idx", first_err_idx, 2'd0);
    chk("rst:valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    run_test("t1_echo", 4, 4, 0, 0, 1'b1, 1'b0);
    chk("t1:ar_cycles", ar_hi_cnt, 4);
    repeat (3) @(negedge ACLK);
    chk("t1:done_held", done, 1'b1);
    chk("t1:pass_held", pass, 1'b1);

    aw_delay = 3;
    run_test("t2_aw_delay", 4, 4, 0, 0, 1'b1, 1'b0);
    chk("t2:awvalid_cycles", aw_len, 4);
    chk("t2:wvalid_cycles", w_len, 1);
    aw_delay = 0;

    flip_idx = 2;
    run_test("t3_bad_read", 4, 4, 1, 2, 1'b0, 1'b0);
    flip_idx = -1;

    berr_idx = 1;
    run_test("t4_slverr", 4, 4, 1, 1, 1'b0, 1'b0);
    berr_idx = -1;

    ar_stuck = 1'b1;
    run_test("t5_ar_timeout", 1, 0, 0, 0, 1'b0, 1'b1);
    chk("t5:ar_cycles", ar_hi_cnt, 16);
    chk("t5:arvalid_low", M_AXI_ARVALID, 1'b0);
    ar_stuck = 1'b0;

    hold_idx = 1;
    push_exp(2, 1);
    @(negedge ACLK); start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    for (int c = 0; c < 200 && !(b_held && M_AXI_BREADY); c++) @(negedge ACLK);
    chk("t6:in_b_wait", (b_held && M_AXI_BREADY), 1'b1);
    #2 ARESET = 1'b1;
    #1;
    chk("t6:bready_async", M_AXI_BREADY, 1'b0);
    chk("t6:busy_async", busy, 1'b0);
    chk("t6:outs_async", {done, pass, timeout, err_count, first_err_idx}, 8'd0);
    chk("t6:valids_async", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_RREADY}, 4'b0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    hold_idx = -1;
    chk("t6:writes_left", wa_q.size(), 0);
    chk("t6:reads_left", ra_q.size(), 0);
    @(negedge ACLK);
    run_test("t6_rerun", 4, 4, 0, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
